// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the floating-point compare unit: op encodings,
// default field widths and the canonical quiet NaN.
package fp_cmp_pkg;

    localparam int unsigned DEFAULT_EXP_W = 8;
    localparam int unsigned DEFAULT_MAN_W = 23;
    localparam int unsigned OP_W          = 3;
    localparam int unsigned NAN_MAX_W     = 128;

    typedef enum logic [OP_W-1:0] {
        OP_FEQ  = 3'b000,
        OP_FLT  = 3'b001,
        OP_FLE  = 3'b010,
        OP_FMIN = 3'b011,
        OP_FMAX = 3'b100
    } fpOpE;

    // Sign 0, exponent all ones, mantissa MSB set; caller truncates to its width.
    function automatic logic [NAN_MAX_W-1:0] canonicalNan(input int unsigned expW,
                                                          input int unsigned manW);
        logic [NAN_MAX_W-1:0] expOnes;
        expOnes = (NAN_MAX_W'(1) << expW) - NAN_MAX_W'(1);
        return (expOnes << manW) | (NAN_MAX_W'(1) << (manW - 1));
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: NaN, signalling NaN, zero and sign.
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = DEFAULT_EXP_W,
    parameter int unsigned MAN_W = DEFAULT_MAN_W,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] operand,
    output logic         is_nan,
    output logic         is_snan,
    output logic         is_zero,
    output logic         sign
);

    logic [EXP_W-1:0] expField;
    logic [MAN_W-1:0] manField;

    assign expField = operand[W-2 -: EXP_W];
    assign manField = operand[MAN_W-1:0];

    assign sign    = operand[W-1];
    assign is_nan  = (&expField) && (|manField);
    assign is_snan = is_nan && !manField[MAN_W-1];
    assign is_zero = (expField == '0) && (manField == '0);

endmodule

// File: rtl/fp_compare_unit.sv
// Two-stage pipelined FEQ/FLT/FLE/FMIN/FMAX unit with valid/ready handshake
// on both sides and a passthrough tag.
module fp_compare_unit
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = DEFAULT_EXP_W,
    parameter int unsigned MAN_W = DEFAULT_MAN_W,
    parameter int unsigned TAG_W = 5,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [W-1:0] CANON_NAN = W'(canonicalNan(EXP_W, MAN_W));

    logic aNan, aSnan, aZero, aSign;
    logic bNan, bSnan, bZero, bSign;
    logic magLt, magEq, ordLt, ordEq;

    logic             v1;
    logic [OP_W-1:0]  op1;
    logic [TAG_W-1:0] tag1;
    logic [W-1:0]     a1, b1;
    logic             aNan1, bNan1, anySnan1, lt1, eq1, bothZero1;

    logic             adv2;
    logic             anyNan, cmpLt, cmpEq;
    logic [W-1:0]     resultC;
    logic             nvC;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classA (
        .operand (in_a),
        .is_nan  (aNan),
        .is_snan (aSnan),
        .is_zero (aZero),
        .sign    (aSign)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classB (
        .operand (in_b),
        .is_nan  (bNan),
        .is_snan (bSnan),
        .is_zero (bZero),
        .sign    (bSign)
    );

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !v1 || adv2;

    // Sign-magnitude total order on raw bits: -0 sorts below +0 here.
    assign magLt = in_a[W-2:0] <  in_b[W-2:0];
    assign magEq = in_a[W-2:0] == in_b[W-2:0];
    assign ordEq = (aSign == bSign) && magEq;

    always_comb begin
        ordLt = 1'b0;
        if (aSign != bSign) begin
            ordLt = aSign;
        end else if (aSign) begin
            ordLt = !magLt && !magEq;
        end else begin
            ordLt = magLt;
        end
    end

    // Stage 1 payload; qualified by v1 so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            op1       <= in_op;
            tag1      <= in_tag;
            a1        <= in_a;
            b1        <= in_b;
            aNan1     <= aNan;
            bNan1     <= bNan;
            anySnan1  <= aSnan || bSnan;
            lt1       <= ordLt;
            eq1       <= ordEq;
            bothZero1 <= aZero && bZero;
        end
    end

    // Comparisons treat the two zeros as equal; min/max keep the raw order.
    assign anyNan = aNan1 || bNan1;
    assign cmpLt  = lt1 && !bothZero1;
    assign cmpEq  = eq1 || bothZero1;

    always_comb begin
        resultC = '0;
        nvC     = 1'b0;
        case (op1)
            OP_FEQ: begin
                resultC = W'(!anyNan && cmpEq);
                nvC     = anySnan1;
            end
            OP_FLT: begin
                resultC = W'(!anyNan && cmpLt);
                nvC     = anyNan;
            end
            OP_FLE: begin
                resultC = W'(!anyNan && (cmpLt || cmpEq));
                nvC     = anyNan;
            end
            OP_FMIN, OP_FMAX: begin
                nvC = anySnan1;
                if (aNan1 && bNan1) begin
                    resultC = CANON_NAN;
                end else if (aNan1) begin
                    resultC = b1;
                end else if (bNan1) begin
                    resultC = a1;
                end else if ((op1 == OP_FMIN) == lt1) begin
                    resultC = a1;
                end else begin
                    resultC = b1;
                end
            end
            default: begin
                resultC = '0;
                nvC     = 1'b0;
            end
        endcase
    end

    // Valid bits and stage 2 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_nv     <= 1'b0;
            out_tag    <= '0;
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
            end
            if (adv2) begin
                out_valid <= v1;
            end
            if (adv2 && v1) begin
                out_result <= resultC;
                out_nv     <= nvC;
                out_tag    <= tag1;
            end
        end
    end

endmodule

// File: tb/tb_fp_compare_unit.sv
// Scoreboard bench for fp_compare_unit at single and double precision.
module tb_fp_compare_unit;
    import fp_cmp_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic [4:0]  tag;
        int          issueCyc;
        bit          chkLat;
    } exp32T;

    typedef struct {
        logic [63:0] res;
        logic        nv;
        logic [4:0]  tag;
    } exp64T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        inValid, inReady, outValid, outReady, outNv;
    logic [2:0]  inOp;
    logic [31:0] inA, inB, outResult;
    logic [4:0]  inTag, outTag;

    logic        dValid, dReady, dOutValid, dOutReady, dOutNv;
    logic [2:0]  dOp;
    logic [63:0] dA, dB, dOutResult;
    logic [4:0]  dTag, dOutTag;

    exp32T q32[$];
    exp64T q64[$];
    exp32T e32;
    exp64T e64;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int idleReq = 0, idleDone = 0;
    int timeoutReq = 0, timeoutDone = 0;

    bit          holdValid = 1'b0;
    logic [37:0] heldVal;
    bit          toggleEn = 1'b0;
    int          togIdx = 0;
    bit   [0:3]  pat = 4'b1001;

    fp_compare_unit dut32 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_op      (inOp),
        .in_a       (inA),
        .in_b       (inB),
        .in_tag     (inTag),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_nv     (outNv),
        .out_tag    (outTag)
    );

    fp_compare_unit #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (dValid),
        .in_ready   (dReady),
        .in_op      (dOp),
        .in_a       (dA),
        .in_b       (dB),
        .in_tag     (dTag),
        .out_valid  (dOutValid),
        .out_ready  (dOutReady),
        .out_result (dOutResult),
        .out_nv     (dOutNv),
        .out_tag    (dOutTag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Consumer backpressure pattern 1,0,0,1 when enabled.
    always @(posedge clk) begin
        if (toggleEn) begin
            #1;
            outReady = pat[2'(togIdx)];
            togIdx++;
        end
    end

    // Monitor: sole owner of the check/error counters.
    always @(negedge clk) begin
        if (idleReq != idleDone) begin
            idleDone = idleReq;
            checks++;
            if (outValid !== 1'b0 || inReady !== 1'b1 || outResult !== 32'h0 ||
                outNv !== 1'b0 || outTag !== 5'd0) begin
                errors++;
                $display("FAIL reset_state: valid=%b ready=%b result=%h nv=%b tag=%0d, required 0 1 00000000 0 0",
                         outValid, inReady, outResult, outNv, outTag);
            end
        end
        if (timeoutReq != timeoutDone) begin
            timeoutDone = timeoutReq;
            checks++;
            errors++;
            $display("FAIL handshake_timeout: pending32=%0d pending64=%0d, required 0 0",
                     q32.size(), q64.size());
        end
        if (rst) begin
            holdValid = 1'b0;
        end else begin
            if (outValid) begin
                if (holdValid) begin
                    checks++;
                    if ({outResult, outNv, outTag} !== heldVal) begin
                        errors++;
                        $display("FAIL stall_hold: got %h, required %h", {outResult, outNv, outTag}, heldVal);
                    end
                end
                if (!outReady) begin
                    holdValid = 1'b1;
                    heldVal   = {outResult, outNv, outTag};
                end else begin
                    holdValid = 1'b0;
                    checks++;
                    if (q32.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: tag=%0d result=%h, required no output", outTag, outResult);
                    end else begin
                        e32 = q32.pop_front();
                        if (outResult !== e32.res || outNv !== e32.nv || outTag !== e32.tag) begin
                            errors++;
                            $display("FAIL result32 tag %0d: got result=%h nv=%b tag=%0d, required result=%h nv=%b tag=%0d",
                                     e32.tag, outResult, outNv, outTag, e32.res, e32.nv, e32.tag);
                        end
                        if (e32.chkLat) begin
                            checks++;
                            if (cyc - e32.issueCyc != 2) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles, required 2", cyc - e32.issueCyc);
                            end
                        end
                    end
                end
            end
            if (dOutValid && dOutReady) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output64: tag=%0d, required no output", dOutTag);
                end else begin
                    e64 = q64.pop_front();
                    if (dOutResult !== e64.res || dOutNv !== e64.nv || dOutTag !== e64.tag) begin
                        errors++;
                        $display("FAIL result64 tag %0d: got result=%h nv=%b tag=%0d, required result=%h nv=%b tag=%0d",
                                 e64.tag, dOutResult, dOutNv, dOutTag, e64.res, e64.nv, e64.tag);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input logic nv,
                         input bit lat);
        int    guard = 0;
        exp32T e;
        inOp = op; inA = a; inB = b; inTag = tag; inValid = 1'b1;
        while (!inReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!inReady) begin
            timeoutReq++;
        end else begin
            e.res = res; e.nv = nv; e.tag = tag; e.issueCyc = cyc; e.chkLat = lat;
            q32.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] tag, input logic [63:0] res, input logic nv);
        int    guard = 0;
        exp64T e;
        dOp = op; dA = a; dB = b; dTag = tag; dValid = 1'b1;
        while (!dReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!dReady) begin
            timeoutReq++;
        end else begin
            e.res = res; e.nv = nv; e.tag = tag;
            q64.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        dValid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q32.size() != 0 || q64.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q32.size() != 0 || q64.size() != 0) timeoutReq++;
        @(negedge clk);
    endtask

    logic [2:0]  tOp  [8] = '{OP_FLT, OP_FEQ, OP_FLE, OP_FMIN, OP_FMAX, OP_FLT, OP_FEQ, OP_FMIN};
    logic [31:0] tA   [8] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'hC0000000,
                              32'hC0000000, 32'h7FC00000, 32'h7FC00000, 32'h00800000};
    logic [31:0] tB   [8] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                              32'h3F800000, 32'h00000000, 32'h7FC00000, 32'h00000001};
    logic [31:0] tRes [8] = '{32'h1, 32'h1, 32'h0, 32'hC0000000,
                              32'h3F800000, 32'h0, 32'h0, 32'h00000001};
    logic        tNv  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        inValid = 1'b0; inOp = '0; inA = '0; inB = '0; inTag = '0; outReady = 1'b1;
        dValid = 1'b0; dOp = '0; dA = '0; dB = '0; dTag = '0; dOutReady = 1'b1;

        // Request presented during reset must be ignored.
        repeat (2) @(negedge clk);
        inValid = 1'b1; inOp = OP_FEQ; inTag = 5'd31;
        @(negedge clk);
        rst = 1'b0; inValid = 1'b0;
        idleReq++;
        @(negedge clk);

        issue(OP_FLT, 32'hBF800000, 32'h3F800000, 5'd1, 32'h1, 1'b0, 1'b1);
        inValid = 1'b0;
        drain();

        issue(OP_FEQ,  32'h00000000, 32'h80000000, 5'd2,  32'h1,        1'b0, 1'b0);
        issue(OP_FLE,  32'h7FC00000, 32'h3F800000, 5'd3,  32'h0,        1'b1, 1'b0);
        issue(OP_FMIN, 32'h00000000, 32'h80000000, 5'd4,  32'h80000000, 1'b0, 1'b0);
        issue(OP_FMAX, 32'h7F800001, 32'h40000000, 5'd5,  32'h40000000, 1'b1, 1'b0);
        issue(OP_FMAX, 32'h7FC00001, 32'h7FC00001, 5'd6,  32'h7FC00000, 1'b0, 1'b0);
        issue(OP_FEQ,  32'h7F800001, 32'h7F800001, 5'd7,  32'h0,        1'b1, 1'b0);
        issue(OP_FLT,  32'h00000000, 32'h80000000, 5'd8,  32'h0,        1'b0, 1'b0);
        issue(OP_FLE,  32'h80000000, 32'h00000000, 5'd9,  32'h1,        1'b0, 1'b0);
        issue(3'b101,  32'h3F800000, 32'h3F800000, 5'd17, 32'h0,        1'b0, 1'b0);
        issue(3'b111,  32'h7F800001, 32'h00000000, 5'd16, 32'h0,        1'b0, 1'b0);
        issue(OP_FLT,  32'hC0000000, 32'hBF800000, 5'd10, 32'h1,        1'b0, 1'b0);
        issue(OP_FMAX, 32'hC0000000, 32'hBF800000, 5'd11, 32'hBF800000, 1'b0, 1'b0);
        issue(OP_FMIN, 32'h3FC00000, 32'h3F800000, 5'd12, 32'h3F800000, 1'b0, 1'b0);
        issue(OP_FEQ,  32'h3F800000, 32'h3F800001, 5'd13, 32'h0,        1'b0, 1'b0);
        issue(OP_FLE,  32'h7F800000, 32'h7F800000, 5'd14, 32'h1,        1'b0, 1'b0);
        issue(OP_FMIN, 32'h7FC00000, 32'hBF800000, 5'd15, 32'hBF800000, 1'b0, 1'b0);
        issue(OP_FLE,  32'h3F800000, 32'hBF800000, 5'd18, 32'h0,        1'b0, 1'b0);
        issue(OP_FEQ,  32'h80000000, 32'h80000000, 5'd19, 32'h1,        1'b0, 1'b0);
        inValid = 1'b0;
        drain();

        // Back-to-back burst under toggling backpressure.
        toggleEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(tOp[i], tA[i], tB[i], 5'(i), tRes[i], tNv[i], 1'b0);
        end
        inValid = 1'b0;
        drain();
        toggleEn = 1'b0;
        @(negedge clk);
        outReady = 1'b1;

        // Reset with two ops in flight; only the following tag 9 may return.
        outReady = 1'b0;
        issue(OP_FLT, 32'hBF800000, 32'h3F800000, 5'd1, 32'h1, 1'b0, 1'b0);
        issue(OP_FEQ, 32'h3F800000, 32'h3F800000, 5'd2, 32'h1, 1'b0, 1'b0);
        rst = 1'b1;
        q32.delete();
        inValid = 1'b1; inOp = OP_FEQ; inTag = 5'd3;
        @(posedge clk);
        @(negedge clk);
        idleReq++;
        rst = 1'b0; inValid = 1'b0; outReady = 1'b1;
        @(negedge clk);
        issue(OP_FEQ, 32'h3F800000, 32'h3F800000, 5'd9, 32'h1, 1'b0, 1'b0);
        inValid = 1'b0;
        drain();

        // Double precision instance.
        issue64(OP_FLT,  64'hBFF0000000000000, 64'h3FF0000000000000, 5'd1, 64'h1, 1'b0);
        issue64(OP_FMIN, 64'h7FF8000000000001, 64'h7FF0000000000001, 5'd2, 64'h7FF8000000000000, 1'b1);
        issue64(OP_FMAX, 64'h3FF0000000000000, 64'h4000000000000000, 5'd3, 64'h4000000000000000, 1'b0);
        issue64(OP_FEQ,  64'h8000000000000000, 64'h0000000000000000, 5'd4, 64'h1, 1'b0);
        drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fp_compare_unit.md
FP_COMPARE_UNIT -- requirements
Module: fp_compare_unit

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter MAN_W, default 23, mantissa (fraction) width; W = 1+EXP_W+MAN_W (32 at defaults).
REQ-003 Parameter TAG_W, default 5, width of the passthrough tag (destination register index).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operation request.
REQ-007 in_ready  out  1  unit accepts the request this cycle.
REQ-008 in_op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, 101-111 reserved.
REQ-009 in_a, in_b  in  W  IEEE-754-style operands.
REQ-010 in_tag  in  TAG_W  returned unchanged with the result.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_result  out  W  compare: bit0 = outcome, upper bits 0; min/max: selected value.
REQ-014 out_nv  out  1  invalid-operation flag for this result.
REQ-015 out_tag  out  TAG_W  tag of this result.

Function
REQ-016 Two-stage pipeline: S1 registers classification and magnitude compare; S2 registers the final result and flags; latency 2 cycles when not stalled.
REQ-017 adv2 = !v2 | out_ready; in_ready = !v1 | adv2; transfer on in_valid & in_ready, output retires on out_valid & out_ready.
REQ-018 Throughput 1 op/cycle with out_ready held high; no bubbles inserted.
REQ-019 While stalled (out_valid & !out_ready), out_result/out_nv/out_tag hold stable; no accepted op is dropped or duplicated.
REQ-020 Classification: NaN = exp all ones & mant!=0; sNaN = NaN & mant MSB 0; zero = exp 0 & mant 0.
REQ-021 +0 and -0 compare equal for FEQ/FLT/FLE.
REQ-022 Ordering uses full sign/exponent/mantissa of BOTH operands (mantissa of B taken from in_b).
REQ-023 FEQ: 1 iff neither NaN and equal; NV = either operand sNaN.
REQ-024 FLT/FLE: result 0 if either NaN, NV = either operand NaN (quiet or signalling).
REQ-025 FMIN/FMAX: -0 ordered below +0; one NaN -> return other operand; both NaN -> canonical NaN (sign 0, exp all ones, mant MSB 1, rest 0); NV = either operand sNaN.
REQ-026 Reserved op: out_result 0, out_nv 0, still occupies a slot and returns its tag.
REQ-027 Simultaneous accept and retire in one cycle is legal at every stage.

Reset
REQ-028 rst clears S1/S2 valid bits; out_valid 0, in_ready 1 the cycle after, out_result 0, out_nv 0, out_tag 0.
REQ-029 rst asserted mid-operation discards all in-flight ops; no result for them ever appears.
REQ-030 in_valid during rst is ignored.

Structure
REQ-031 Shared package fp_cmp_pkg holds op encodings, default EXP_W/MAN_W, and a canonical-NaN function of EXP_W/MAN_W.
REQ-032 One sub-module fp_classify (combinational, instanced twice) yields is_nan, is_snan, is_zero, sign.
REQ-033 Target size 150-300 lines of RTL.

Verification
REQ-034 FLT a=0xBF800000 (-1.0), b=0x3F800000 (1.0) -> out_result=1, nv=0, two cycles after accept.
REQ-035 FEQ a=0x00000000, b=0x80000000 -> 1, nv=0; FLE a=0x7FC00000, b=0x3F800000 -> 0, nv=1.
REQ-036 FMIN a=0x00000000, b=0x80000000 -> 0x80000000; FMAX a=0x7F800001 (sNaN), b=0x40000000 -> 0x40000000, nv=1; FMAX both 0x7FC00001 -> 0x7FC00000.
REQ-037 Back-to-back 8 ops, tags 0-7, out_ready toggled 1,0,0,1,...: results in order, none lost, outputs stable while stalled.
REQ-038 rst asserted with 2 ops in flight -> out_valid 0 next cycle; following op with tag 9 returns only tag 9.
REQ-039 Parameter EXP_W=11, MAN_W=52: FLT a=0xBFF0000000000000, b=0x3FF0000000000000 -> 1; FMIN both NaN -> 0x7FF8000000000000.
